multicycle_control: RTL

Main sequencing FSM for the multi-cycle RV32 subset datapath (add, sub, and, or, lw, sw, beq). Each cycle it drives the datapath strobes, register-file write enable, memory request and the 2-bit `aluOp` consumed by the ALU control decoder. It handshakes with a variable-latency unified memory and guards each transfer with a timeout. It halts on an illegal opcode or a memory timeout and counts retired instructions.

---
 rtl/datapath_pkg.sv | 56 +++++
 rtl/mem_wait_timer.sv | 29 ++
 rtl/multicycle_control.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared types and encodings for the multi-cycle RV32 subset datapath control.
package datapath_pkg;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_MEM_WB,
        ST_MEM_WR,
        ST_EXEC_R,
        ST_R_WB,
        ST_BRANCH,
        ST_HALT
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // aluOp codes, also consumed by the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'b00,
        FAULT_ILLEGAL = 2'b01,
        FAULT_TIMEOUT = 2'b10
    } fault_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       pc_source;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles in a memory state and flags the last tolerated one.
module mem_wait_timer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic ready,
    output logic timeout_c
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Any cycle that is not a stalled memory cycle leaves the counter at zero,
    // so it is already clear whenever a memory state is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (active && !ready) begin
            count <= count + CW'(1);
        end else begin
            count <= '0;
        end
    end

    assign timeout_c = active && !ready && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Main sequencing FSM for the multi-cycle RV32 subset datapath.
import datapath_pkg::*;

module multicycle_control #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       aluOp,
    output logic             pc_source,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired
);
    state_t     state, state_next;
    fault_t     fault_q, fault_next;
    logic [6:0] op_q;
    ctrl_t      ctrl;
    logic       retire_c;
    logic       timeout_c;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .active    (is_mem_state(state)),
        .ready     (mem_ready),
        .timeout_c (timeout_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_FETCH;
            fault_q <= FAULT_NONE;
            op_q    <= '0;
            retired <= '0;
        end else begin
            state   <= state_next;
            fault_q <= fault_next;
            if (state == ST_DECODE) begin
                op_q <= opcode;
            end
            if (retire_c) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

    // Moore strobes per state; only the fetch load and store retire depend on mem_ready.
    always_comb begin
        ctrl       = '0;
        state_next = state;
        fault_next = fault_q;
        retire_c   = 1'b0;
        unique case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_next    = ST_DECODE;
                end else if (timeout_c) begin
                    state_next = ST_HALT;
                    fault_next = FAULT_TIMEOUT;
                end
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_R:         state_next = ST_EXEC_R;
                    OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                    OP_BEQ:       state_next = ST_BRANCH;
                    default: begin
                        state_next = ST_HALT;
                        fault_next = FAULT_ILLEGAL;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                state_next     = (op_q == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_next = ST_MEM_WB;
                end else if (timeout_c) begin
                    state_next = ST_HALT;
                    fault_next = FAULT_TIMEOUT;
                end
            end
            ST_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                retire_c        = 1'b1;
                state_next      = ST_FETCH;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire_c   = 1'b1;
                    state_next = ST_FETCH;
                end else if (timeout_c) begin
                    state_next = ST_HALT;
                    fault_next = FAULT_TIMEOUT;
                end
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNCT;
                state_next     = ST_R_WB;
            end
            ST_R_WB: begin
                ctrl.reg_write = 1'b1;
                retire_c       = 1'b1;
                state_next     = ST_FETCH;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_BR;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 1'b1;
                retire_c           = 1'b1;
                state_next         = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign i_or_d        = ctrl.i_or_d;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign reg_write     = ctrl.reg_write;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign aluOp         = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign halted        = (state == ST_HALT);
    assign fault         = fault_q;

endmodule
